// File: rtl/affine_sched_addr_gen.sv
// Affine loop-nest address generator with an affine issue schedule, valid/ready
// handshake, start/done control and optional automatic repeat.
module affine_sched_addr_gen #(
  parameter int unsigned NUM_DIMS = 6,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned CYC_W    = 16,
  parameter int unsigned DIM_W    = $clog2(NUM_DIMS + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clk_en,
  input  logic                              flush,
  input  logic                              start,
  input  logic                              repeat_mode,
  input  logic [DIM_W-1:0]                  dimensionality,
  input  logic [NUM_DIMS-1:0][CNT_W-1:0]    ranges,
  input  logic [NUM_DIMS-1:0][ADDR_W-1:0]   strides,
  input  logic [ADDR_W-1:0]                 starting_addr,
  input  logic [NUM_DIMS-1:0][CYC_W-1:0]    sched_strides,
  input  logic [CYC_W-1:0]                  sched_offset,
  input  logic                              ready,
  output logic [ADDR_W-1:0]                 addr_out,
  output logic                              valid_out,
  output logic                              busy,
  output logic                              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                            state, state_next;
  logic [NUM_DIMS-1:0][CNT_W-1:0]    cnt;
  logic [NUM_DIMS-1:0][ADDR_W-1:0]   addr_loc;
  logic [NUM_DIMS-1:0][CYC_W-1:0]    sched_loc;
  logic [CYC_W-1:0]                  cycle_cnt;
  logic [CYC_W-1:0]                  sched_time;
  logic [DIM_W-1:0]                  dim_eff;
  logic [NUM_DIMS-1:0]               active;
  logic [NUM_DIMS-1:0]               at_max;
  logic [NUM_DIMS-1:0]               upd;
  logic [CNT_W-1:0]                  range_m1;
  logic                              carry;
  logic                              last;
  logic                              step;
  logic                              stall;

  // Active-dim mask, carry chain, address and schedule sums
  always_comb begin
    dim_eff    = (dimensionality > DIM_W'(NUM_DIMS)) ? DIM_W'(NUM_DIMS) : dimensionality;
    active     = '0;
    at_max     = '0;
    upd        = '0;
    range_m1   = '0;
    carry      = 1'b1;
    last       = 1'b1;
    addr_out   = starting_addr;
    sched_time = sched_offset;
    for (int unsigned d = 0; d < NUM_DIMS; d++) begin
      active[d] = (DIM_W'(d) < dim_eff);
      range_m1  = (ranges[d] == '0) ? '0 : ranges[d] - CNT_W'(1);
      at_max[d] = (cnt[d] == range_m1);
      if (active[d]) begin
        upd[d]     = carry;
        carry      = carry & at_max[d];
        last       = last & at_max[d];
        addr_out   = addr_out + addr_loc[d];
        sched_time = sched_time + sched_loc[d];
      end
    end
  end

  assign valid_out = clk_en & (state == RUN) & (cycle_cnt >= sched_time);
  assign step      = valid_out & ready;
  assign stall     = valid_out & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clk_en) begin
      if (flush) begin
        state_next = IDLE;
      end else begin
        case (state)
          IDLE, DONE: if (start) state_next = RUN;
          RUN:        if (step && last && !repeat_mode) state_next = DONE;
          default:    state_next = IDLE;
        endcase
      end
    end
  end

  // Iteration counters, locs and cycle counter; anything outside an ongoing
  // RUN (including the pass-final step) holds them at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      addr_loc  <= '0;
      sched_loc <= '0;
      cycle_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clk_en) begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (flush || (state != RUN) || (step && last)) begin
        cnt       <= '0;
        addr_loc  <= '0;
        sched_loc <= '0;
        cycle_cnt <= '0;
      end else if (!stall) begin
        cycle_cnt <= cycle_cnt + CYC_W'(1);
        if (step) begin
          for (int unsigned d = 0; d < NUM_DIMS; d++) begin
            if (upd[d]) begin
              if (at_max[d]) begin
                cnt[d]       <= '0;
                addr_loc[d]  <= '0;
                sched_loc[d] <= '0;
              end else begin
                cnt[d]       <= cnt[d] + CNT_W'(1);
                addr_loc[d]  <= addr_loc[d] + strides[d];
                sched_loc[d] <= sched_loc[d] + sched_strides[d];
              end
            end
          end
        end
      end
    end
  end

endmodule
